// File: rtl/elbeth_nibble_fifo.sv
// elbeth_nibble_fifo: small synchronous FIFO buffering nibbles from an upstream
// 2-to-1 mux. Valid/ready on both sides, sticky overflow flag, synchronous flush.
module elbeth_nibble_fifo #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_wr_ready;
    logic              r_rd_valid;

    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_full;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_ovf_nxt;

    // Handshakes qualified only by registered flags, so no rd_ready -> wr_ready path.
    assign w_wr_fire = wr_valid & r_wr_ready;
    assign w_rd_fire = rd_ready & r_rd_valid;
    assign w_full    = (r_count == CNT_W'(DEPTH));

    // Next occupancy and overflow; flush overrides every other update.
    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = r_overflow;
        if (clr) begin
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            if (w_wr_fire && !w_rd_fire) begin
                w_count_nxt = r_count + CNT_W'(1);
            end else if (w_rd_fire && !w_wr_fire) begin
                w_count_nxt = r_count - CNT_W'(1);
            end
            if (wr_valid && w_full) begin
                w_ovf_nxt = 1'b1;
            end
        end
    end

    // Pointers, occupancy and status flags; flags are precomputed from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_wr_ready <= 1'b1;
            r_rd_valid <= 1'b0;
        end else begin
            if (clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_fire) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_rd_fire) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
            r_count    <= w_count_nxt;
            r_overflow <= w_ovf_nxt;
            r_wr_ready <= (w_count_nxt != CNT_W'(DEPTH));
            r_rd_valid <= (w_count_nxt != '0);
        end
    end

    // Storage is not reset; an entry changes only on an accepted, non-flushed write.
    always_ff @(posedge clk) begin
        if (w_wr_fire && !clr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign wr_ready = r_wr_ready;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_elbeth_nibble_fifo.sv
// Directed plus randomized bench for elbeth_nibble_fifo with a queue scoreboard.
module tb_elbeth_nibble_fifo;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              clr;

    elbeth_nibble_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .count    (count),
        .overflow (overflow),
        .clr      (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] exp_q [$];
    logic              m_ovf;
    int                n_pass;
    int                n_total;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Compare all status outputs against the scoreboard model.
    task automatic chk_state(input string tag);
        chk({tag, ".count"},    32'(count),    32'(exp_q.size()));
        chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(exp_q.size() != DEPTH));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    // One clock cycle: drive at negedge, check before the edge, update model after it.
    task automatic cycle(input string tag, input logic wv, input logic [DATA_W-1:0] wd,
                         input logic rr, input logic cl);
        bit wf;
        bit rf;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        clr      = cl;
        #1;
        chk_state(tag);
        wf = wv && (exp_q.size() < DEPTH);
        rf = rr && (exp_q.size() > 0);
        if (rf && !cl) chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_q[0]));
        @(posedge clk);
        if (cl) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (wv && exp_q.size() == DEPTH) m_ovf = 1'b1;
            if (rf) void'(exp_q.pop_front());
            if (wf) exp_q.push_back(wd);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] seq [4];
        n_pass   = 0;
        n_total  = 0;
        m_ovf    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        clr      = 1'b0;
        rst_n    = 1'b0;
        seq[0] = 4'h3; seq[1] = 4'h9; seq[2] = 4'hC; seq[3] = 4'h5;

        // Reset state while held
        #12;
        chk_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill to full without reading
        for (int i = 0; i < 4; i++) cycle("fill", 1'b1, seq[i], 1'b0, 1'b0);
        chk("full.count",    32'(count),    32'd4);
        chk("full.wr_ready", 32'(wr_ready), 32'd0);
        chk("full.rd_valid", 32'(rd_valid), 32'd1);
        chk("full.rd_data",  32'(rd_data),  32'h3);

        // Write attempt while full sets sticky overflow, drops data
        cycle("ovf", 1'b1, 4'hF, 1'b0, 1'b0);
        chk("ovf.flag",  32'(overflow), 32'd1);
        chk("ovf.count", 32'(count),    32'd4);

        // Full with both sides active: read only, slot frees next cycle
        cycle("fullrw", 1'b1, 4'h7, 1'b1, 1'b0);
        chk("fullrw.wr_ready", 32'(wr_ready), 32'd1);
        chk("fullrw.count",    32'(count),    32'd3);

        // Drain the rest, then read attempt while empty
        for (int i = 0; i < 3; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
        chk("drain.ovf_sticky", 32'(overflow), 32'd1);
        cycle("emptyrd", 1'b0, '0, 1'b1, 1'b0);

        // Empty with both sides active: write only, latency-1 visibility
        cycle("emptyrw", 1'b1, 4'h2, 1'b1, 1'b0);
        chk("emptyrw.rd_data", 32'(rd_data), 32'h2);
        cycle("w2", 1'b1, 4'h3, 1'b0, 1'b0);

        // Steady state at count 2 across pointer wraps
        for (int i = 0; i < 10; i++) cycle("stream", 1'b1, DATA_W'(i + 4), 1'b1, 1'b0);
        chk("stream.count", 32'(count), 32'd2);

        // Count 3 with overflow set, flush with a concurrent write
        cycle("w3", 1'b1, 4'hB, 1'b0, 1'b0);
        chk("preclr.count", 32'(count),    32'd3);
        chk("preclr.ovf",   32'(overflow), 32'd1);
        cycle("clr", 1'b1, 4'hE, 1'b1, 1'b1);
        chk("clr.count",    32'(count),    32'd0);
        chk("clr.ovf",      32'(overflow), 32'd0);
        chk("clr.rd_valid", 32'(rd_valid), 32'd0);

        // Asynchronous reset mid-operation between edges
        cycle("pre_rst_a", 1'b1, 4'h1, 1'b0, 1'b0);
        cycle("pre_rst_b", 1'b1, 4'h6, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_ovf = 1'b0;
        chk("async_rst.count",    32'(count),    32'd0);
        chk("async_rst.rd_valid", 32'(rd_valid), 32'd0);
        chk("async_rst.wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cycle("post_rst", 1'b1, 4'hA, 1'b0, 1'b0);
        chk("post_rst.rd_valid", 32'(rd_valid), 32'd1);
        chk("post_rst.rd_data",  32'(rd_data),  32'hA);

        // Random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), DATA_W'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
        end
        chk_state("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
